pr_slot_sequencer: RTL and testbench
====================================

# pr_slot_sequencer

Per-core-slot sequencer that isolates, drains and resets one reconfigurable RISC-V core region so it can be partially reconfigured without losing or corrupting traffic. Sits between the scheduler's descriptor port and the core's PR wrapper: gates incoming descriptors, tracks outstanding slots, drives `core_reset` and the PR decouple signal, and handshakes with the PR controller.

## Interface
- `SLOT_COUNT`, 16: maximum outstanding descriptors per core.
- `CNT_WIDTH`, $clog2(SLOT_COUNT+1): width of the busy-slot counter.
- `DRAIN_TIMEOUT`, 65535: cycles allowed in DRAIN before a forced isolate.
- `RESET_CYCLES`, 16: cycles `core_reset` is held after reload or reset; must be ≥1.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pr_req` in 1: level; request reconfiguration of this slot.
- `pr_ack` out 1: slot isolated; bitstream may be loaded.
- `pr_done` in 1: single-cycle pulse; load complete.
- `in_desc_valid_s` in 1: upstream descriptor valid.
- `in_desc_taken_s` out 1: upstream accept.
- `in_desc_valid_m` out 1: valid toward core wrapper.
- `in_desc_taken_m` in 1: core wrapper accept.
- `out_desc_valid`, `out_desc_ready`, `out_desc_2nd` in 1 each: monitored completion channel.
- `dma_busy` in 1: wrapper has DMA commands in flight.
- `err_clr` in 1: clears `err`.
- `core_reset` out 1: core reset, active high.
- `decouple` out 1: PR boundary isolation.
- `busy_slots` out CNT_WIDTH: outstanding descriptor count.
- `state` out 3: current FSM state encoding.
- `err` out 2: sticky; [0] drain timeout, [1] completion underflow.

## Operation
- States: RUN=0, DRAIN=1, ISOLATE=2, HOLD=3. Moore outputs decoded from the registered state.
- Reset: state=HOLD, hold counter=RESET_CYCLES; `core_reset`=1, `decouple`=0, `pr_ack`=0, `busy_slots`=0, `err`=0, descriptor gate closed.
- RUN: `in_desc_valid_m = in_desc_valid_s & (busy_slots < SLOT_COUNT)`; `in_desc_taken_s = in_desc_taken_m & in_desc_valid_m`. `pr_req`=1 → DRAIN.
- All other states: `in_desc_valid_m`=0, `in_desc_taken_s`=0.
- Counter: +1 on `in_desc_valid_m & in_desc_taken_m`; −1 on `out_desc_valid & out_desc_ready & !out_desc_2nd`; both in the same cycle → unchanged. A completion while count=0 holds 0 and sets `err[1]`.
- DRAIN: on entry the timeout counter loads 0. If `busy_slots==0 & !dma_busy` → ISOLATE. If `pr_req`=0 → RUN (abort, no reset). If the timeout counter reaches DRAIN_TIMEOUT → set `err[0]` and go to ISOLATE. Drain-complete takes priority over abort, and abort takes priority over timeout.
- ISOLATE: `decouple`=1, `core_reset`=1, `pr_ack`=1. `pr_req` is ignored. `pr_done` → HOLD.
- HOLD: `core_reset`=1, `decouple`=0, `busy_slots` forced to 0. The counter decrements each cycle; at 0 → RUN.
- `pr_done` outside ISOLATE is ignored. `err_clr` clears `err`; if `err_clr` coincides with a new error, the set wins.

## Timing
- `pr_req` sampled high in RUN → DRAIN on the next edge; the gate is closed in that same cycle.
- A descriptor handshake that completes in the last RUN cycle is counted.
- With an empty core and `dma_busy`=0, `pr_ack` asserts 2 cycles after `pr_req`.
- `pr_done` → HOLD next cycle. `core_reset` stays high exactly RESET_CYCLES cycles in HOLD, then RUN.
- After deassertion of `rst_n`, the first accept is possible RESET_CYCLES+1 cycles later.
- `rst_n` asserted mid-operation forces the reset values asynchronously; `pr_ack` drops immediately.

## Structure
- Shared package: state encoding constants (ST_RUN, ST_DRAIN, ST_ISOLATE, ST_HOLD) and err bit indices. Wrappers and status logic reuse these.
- Single module. An optional sub-module `slot_credit_counter` holds the up/down counter with saturation and underflow flag.

## Test plan
- Reset, then a 20-cycle idle window: `core_reset`=1 for 16 cycles, then 0. `state`=0 and `busy_slots`=0.
- Accept 16 descriptors without completions: `busy_slots`=16, and the 17th `in_desc_valid_s` sees `in_desc_taken_s`=0. One completion → 15, and the next descriptor is accepted.
- `pr_req` with 3 outstanding descriptors and `dma_busy` pulsed: state stays DRAIN until 3 completions and `dma_busy`=0. `pr_ack` rises the cycle after; `pr_done` yields 16 cycles of `core_reset`, then RUN.
- `pr_req` with 1 outstanding descriptor that never completes, DRAIN_TIMEOUT=100: ISOLATE reached at cycle 101 with `err`=2'b01. `err_clr` → 0.
- `pr_req` dropped after 5 DRAIN cycles: return to RUN, with no `core_reset`, `decouple` or `pr_ack` ever asserted.
- Accept and completion in the same cycle at count 4 → stays 4. A completion at count 0 → `err[1]`=1, count stays 0.

Source files
------------

// File: rtl/pr_slot_sequencer_pkg.sv
// Shared definitions for the PR slot sequencer: FSM state encoding and
// bit positions inside the sticky error vector.
package pr_slot_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_ISOLATE = 3'd2,
        ST_HOLD    = 3'd3
    } state_e;

    localparam int ERR_W         = 2;
    localparam int ERR_TIMEOUT   = 0;
    localparam int ERR_UNDERFLOW = 1;

endpackage

// File: rtl/pr_slot_sequencer_credit.sv
// Up/down counter of outstanding descriptor slots. Saturates at SLOT_COUNT,
// holds at zero on a completion with nothing outstanding and flags it.
// A simultaneous increment and decrement leaves the count unchanged.
module slot_credit_counter #(
    parameter int SLOT_COUNT = 16,
    parameter int CNT_WIDTH  = $clog2(SLOT_COUNT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 inc,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 underflow
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    // Next count and underflow pulse; a clear overrides all traffic.
    always_comb begin
        count_d   = count_q;
        underflow = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (inc && !dec) begin
            if (count_q < CNT_WIDTH'(SLOT_COUNT)) begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end else if (dec && !inc) begin
            if (count_q == '0) begin
                underflow = 1'b1;
            end else begin
                count_d = count_q - CNT_WIDTH'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // While cleared the count reads zero immediately, not one cycle later.
    assign count = clr ? '0 : count_q;

endmodule

// File: rtl/pr_slot_sequencer.sv
// Per-core-slot sequencer: gates descriptors toward a reconfigurable core,
// tracks outstanding slots, and walks RUN -> DRAIN -> ISOLATE -> HOLD -> RUN
// around a partial reconfiguration, driving core_reset, decouple and pr_ack.
//
// Descriptor handshake: a descriptor moves on a cycle where both
// in_desc_valid_m and in_desc_taken_m are high; in_desc_taken_s mirrors that
// event upstream. Valid toward the core is only offered in RUN while a slot
// is free, so the upstream side never sees an accept outside RUN.
module pr_slot_sequencer
    import pr_slot_sequencer_pkg::*;
#(
    parameter int SLOT_COUNT    = 16,
    parameter int CNT_WIDTH     = $clog2(SLOT_COUNT + 1),
    parameter int DRAIN_TIMEOUT = 65535,
    parameter int RESET_CYCLES  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pr_req,
    output logic                 pr_ack,
    input  logic                 pr_done,
    input  logic                 in_desc_valid_s,
    output logic                 in_desc_taken_s,
    output logic                 in_desc_valid_m,
    input  logic                 in_desc_taken_m,
    input  logic                 out_desc_valid,
    input  logic                 out_desc_ready,
    input  logic                 out_desc_2nd,
    input  logic                 dma_busy,
    input  logic                 err_clr,
    output logic                 core_reset,
    output logic                 decouple,
    output logic [CNT_WIDTH-1:0] busy_slots,
    output logic [2:0]           state,
    output logic [1:0]           err
);

    localparam int TMR_W  = $clog2(DRAIN_TIMEOUT + 1);
    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [ERR_W-1:0]   err_q, err_d;

    logic               timeout_set;
    logic               cnt_inc;
    logic               cnt_dec;
    logic               cnt_clr;
    logic               cnt_underflow;

    assign cnt_inc = in_desc_valid_m & in_desc_taken_m;
    assign cnt_dec = out_desc_valid & out_desc_ready & ~out_desc_2nd;
    assign cnt_clr = (state_q == ST_HOLD);

    slot_credit_counter #(
        .SLOT_COUNT (SLOT_COUNT),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_credit (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (cnt_clr),
        .inc        (cnt_inc),
        .dec        (cnt_dec),
        .count      (busy_slots),
        .underflow  (cnt_underflow)
    );

    // Next state, drain timer and hold countdown. Drain-complete beats abort,
    // abort beats timeout. The timer sits at zero outside DRAIN so it always
    // starts from zero on entry.
    always_comb begin
        state_d     = state_q;
        tmr_d       = '0;
        hold_d      = hold_q;
        timeout_set = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (pr_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (busy_slots == '0 && !dma_busy) begin
                    state_d = ST_ISOLATE;
                end else if (!pr_req) begin
                    state_d = ST_RUN;
                end else if (tmr_q == TMR_W'(DRAIN_TIMEOUT)) begin
                    state_d     = ST_ISOLATE;
                    timeout_set = 1'b1;
                end
            end
            ST_ISOLATE: begin
                if (pr_done) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_W'(RESET_CYCLES);
                end
            end
            ST_HOLD: begin
                hold_d = hold_q - HOLD_W'(1);
                if (hold_q == HOLD_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_HOLD;
                hold_d  = HOLD_W'(RESET_CYCLES);
            end
        endcase
    end

    // Sticky errors: clear first, so a coinciding new error still lands.
    always_comb begin
        err_d = err_clr ? '0 : err_q;
        if (timeout_set) begin
            err_d[ERR_TIMEOUT] = 1'b1;
        end
        if (cnt_underflow) begin
            err_d[ERR_UNDERFLOW] = 1'b1;
        end
    end

    // Moore outputs from the registered state plus the RUN-only descriptor gate.
    always_comb begin
        pr_ack          = 1'b0;
        decouple        = 1'b0;
        core_reset      = 1'b0;
        in_desc_valid_m = 1'b0;
        case (state_q)
            ST_RUN: begin
                in_desc_valid_m = in_desc_valid_s & (busy_slots < CNT_WIDTH'(SLOT_COUNT));
            end
            ST_ISOLATE: begin
                pr_ack     = 1'b1;
                decouple   = 1'b1;
                core_reset = 1'b1;
            end
            ST_HOLD: begin
                core_reset = 1'b1;
            end
            default: begin
                pr_ack = 1'b0;
            end
        endcase
        in_desc_taken_s = in_desc_taken_m & in_desc_valid_m;
    end

    // State, timer, hold counter and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HOLD;
            tmr_q   <= '0;
            hold_q  <= HOLD_W'(RESET_CYCLES);
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    assign state = state_q;
    assign err   = err_q;

endmodule

// File: tb/tb_pr_slot_sequencer.sv
// Directed bench for pr_slot_sequencer with a shortened drain timeout.
module tb_pr_slot_sequencer;

    logic       clk;
    logic       rst_n;
    logic       pr_req;
    logic       pr_ack;
    logic       pr_done;
    logic       in_desc_valid_s;
    logic       in_desc_taken_s;
    logic       in_desc_valid_m;
    logic       in_desc_taken_m;
    logic       out_desc_valid;
    logic       out_desc_ready;
    logic       out_desc_2nd;
    logic       dma_busy;
    logic       err_clr;
    logic       core_reset;
    logic       decouple;
    logic [4:0] busy_slots;
    logic [2:0] state;
    logic [1:0] err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       vs;
        logic       tm;
        logic       ov;
        logic       orr;
        logic       o2;
        logic       clr;
        logic       exp_taken;
        logic       exp_valid;
        logic [4:0] exp_busy;
        logic [1:0] exp_err;
    } vec_t;

    vec_t vecs[16];

    pr_slot_sequencer #(
        .SLOT_COUNT    (16),
        .DRAIN_TIMEOUT (100),
        .RESET_CYCLES  (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pr_req          (pr_req),
        .pr_ack          (pr_ack),
        .pr_done         (pr_done),
        .in_desc_valid_s (in_desc_valid_s),
        .in_desc_taken_s (in_desc_taken_s),
        .in_desc_valid_m (in_desc_valid_m),
        .in_desc_taken_m (in_desc_taken_m),
        .out_desc_valid  (out_desc_valid),
        .out_desc_ready  (out_desc_ready),
        .out_desc_2nd    (out_desc_2nd),
        .dma_busy        (dma_busy),
        .err_clr         (err_clr),
        .core_reset      (core_reset),
        .decouple        (decouple),
        .busy_slots      (busy_slots),
        .state           (state),
        .err             (err)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_idle();
        in_desc_valid_s = 1'b0;
        in_desc_taken_m = 1'b0;
        out_desc_valid  = 1'b0;
        out_desc_ready  = 1'b0;
        out_desc_2nd    = 1'b0;
        err_clr         = 1'b0;
        pr_done         = 1'b0;
    endtask

    // Counts core_reset cycles spent in HOLD until RUN returns (bounded).
    task automatic wait_hold(input string name);
        int n;
        int guard;
        n = 0;
        guard = 0;
        while (state == 3'd3 && guard < 40) begin
            if (core_reset) n++;
            guard++;
            tick();
        end
        check({name, "_reset_cycles"}, n, 16);
        check({name, "_run"}, state, 0);
        check({name, "_reset_low"}, core_reset, 0);
    endtask

    initial begin
        int cnt;
        logic seen;

        // Vectors start from RUN with nothing outstanding and no errors.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 2'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 2'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 2'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 2'd0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 2'd0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 2'd0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 2'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 2'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 2'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 2'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 2'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 2'd0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd2};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd2};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0};

        // Reset
        rst_n    = 1'b0;
        pr_req   = 1'b0;
        dma_busy = 1'b0;
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", state, 3);
        check("rst_core_reset", core_reset, 1);
        check("rst_decouple", decouple, 0);
        check("rst_pr_ack", pr_ack, 0);
        check("rst_busy", busy_slots, 0);
        check("rst_err", err, 0);
        in_desc_valid_s = 1'b1;
        #1;
        check("rst_gate", in_desc_valid_m, 0);
        in_desc_valid_s = 1'b0;
        rst_n = 1'b1;

        // Idle window: core_reset high for the first 16 cycles only
        for (int c = 0; c < 20; c++) begin
            check($sformatf("idle_core_reset_%0d", c), core_reset, (c < 16) ? 1 : 0);
            tick();
        end
        check("idle_state", state, 0);
        check("idle_busy", busy_slots, 0);

        // Table-driven counter / gate / error vectors
        for (int i = 0; i < 16; i++) begin
            in_desc_valid_s = vecs[i].vs;
            in_desc_taken_m = vecs[i].tm;
            out_desc_valid  = vecs[i].ov;
            out_desc_ready  = vecs[i].orr;
            out_desc_2nd    = vecs[i].o2;
            err_clr         = vecs[i].clr;
            mid();
            check($sformatf("vec%0d_taken", i), in_desc_taken_s, vecs[i].exp_taken);
            check($sformatf("vec%0d_valid", i), in_desc_valid_m, vecs[i].exp_valid);
            tick();
            check($sformatf("vec%0d_busy", i), busy_slots, vecs[i].exp_busy);
            check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
        end
        set_idle();

        // Fill all 16 slots, 17th is refused
        in_desc_valid_s = 1'b1;
        in_desc_taken_m = 1'b1;
        for (int i = 0; i < 16; i++) begin
            mid();
            check($sformatf("fill_take_%0d", i), in_desc_taken_s, 1);
            tick();
        end
        mid();
        check("fill_busy16", busy_slots, 16);
        check("fill_17th_taken", in_desc_taken_s, 0);
        check("fill_17th_valid", in_desc_valid_m, 0);
        tick();
        set_idle();
        out_desc_valid = 1'b1;
        out_desc_ready = 1'b1;
        tick();
        out_desc_valid = 1'b0;
        check("fill_busy15", busy_slots, 15);
        in_desc_valid_s = 1'b1;
        in_desc_taken_m = 1'b1;
        mid();
        check("fill_retake", in_desc_taken_s, 1);
        tick();
        set_idle();
        check("fill_busy16_again", busy_slots, 16);
        out_desc_valid = 1'b1;
        out_desc_ready = 1'b1;
        repeat (16) tick();
        set_idle();
        check("fill_emptied", busy_slots, 0);

        // pr_done outside ISOLATE is ignored
        pr_done = 1'b1;
        tick();
        pr_done = 1'b0;
        check("stray_done_state", state, 0);
        check("stray_done_reset", core_reset, 0);

        // Drain with 3 outstanding and dma_busy; last RUN handshake counts
        dma_busy = 1'b1;
        in_desc_valid_s = 1'b1;
        in_desc_taken_m = 1'b1;
        repeat (2) tick();
        pr_req = 1'b1;
        mid();
        check("drain_last_run_take", in_desc_taken_s, 1);
        tick();
        check("drain_state", state, 1);
        check("drain_busy3", busy_slots, 3);
        mid();
        check("drain_gate_valid", in_desc_valid_m, 0);
        check("drain_gate_taken", in_desc_taken_s, 0);
        in_desc_valid_s = 1'b0;
        in_desc_taken_m = 1'b0;
        out_desc_valid  = 1'b1;
        out_desc_ready  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("drain_hold_%0d", i), state, 1);
        end
        out_desc_valid = 1'b0;
        check("drain_busy0", busy_slots, 0);
        repeat (2) tick();
        check("drain_dma_wait", state, 1);
        check("drain_no_ack", pr_ack, 0);
        dma_busy = 1'b0;
        tick();
        check("iso_state", state, 2);
        check("iso_pr_ack", pr_ack, 1);
        check("iso_decouple", decouple, 1);
        check("iso_core_reset", core_reset, 1);
        pr_req = 1'b0;
        tick();
        check("iso_ignores_req", state, 2);
        pr_done = 1'b1;
        tick();
        pr_done = 1'b0;
        check("hold_state", state, 3);
        check("hold_decouple", decouple, 0);
        check("hold_pr_ack", pr_ack, 0);
        wait_hold("drain");

        // Drain timeout with one descriptor that never completes
        in_desc_valid_s = 1'b1;
        in_desc_taken_m = 1'b1;
        tick();
        set_idle();
        pr_req = 1'b1;
        tick();
        check("tmo_enter", state, 1);
        cnt = 0;
        while (state == 3'd1 && cnt < 300) begin
            cnt++;
            tick();
        end
        check("tmo_drain_cycles", cnt, 101);
        check("tmo_state", state, 2);
        check("tmo_err", err, 1);
        pr_req = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("tmo_err_clr", err, 0);
        pr_done = 1'b1;
        tick();
        pr_done = 1'b0;
        check("tmo_hold_busy", busy_slots, 0);
        wait_hold("tmo");
        check("tmo_busy_after", busy_slots, 0);

        // Abort after 5 DRAIN cycles: nothing isolating ever asserts
        dma_busy = 1'b1;
        pr_req = 1'b1;
        tick();
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("abort_drain_%0d", i), state, 1);
            seen = seen | core_reset | decouple | pr_ack;
            if (i == 4) pr_req = 1'b0;
            tick();
        end
        check("abort_run", state, 0);
        seen = seen | core_reset | decouple | pr_ack;
        check("abort_no_isolation", seen, 0);
        dma_busy = 1'b0;

        // Empty core: pr_ack two cycles after pr_req, then async reset
        pr_req = 1'b1;
        tick();
        check("ack_lat_c1", pr_ack, 0);
        tick();
        check("ack_lat_c2", pr_ack, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pr_ack", pr_ack, 0);
        check("async_state", state, 3);
        check("async_core_reset", core_reset, 1);
        pr_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
